lut_loader: RTL and testbench

Runtime loader for the activation lookup tables used by the LSTM datapath. It accepts a valid/ready stream of signed 16-bit table entries and writes them into a table RAM at addresses 0..DEPTH-1. While loading it checks that the entries are monotonically non-decreasing, as sigmoid and tanh tables must be, and accumulates a checksum for host readback. It is the writer end of the table that the activation lookup reads; `busy` holds the lookup path off while a load is in progress.

---
 rtl/lstm_pkg.sv | 18 +
 rtl/lut_loader.sv | 94 +++++++++
 tb/tb_lut_loader.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lstm_pkg.sv
// Shared types for the LSTM datapath: activation-table entry, checksum, and the
// lookup-table loader state encoding.
package lstm_pkg;

  localparam int LUT_WIDTH = 16;
  localparam int CHECKSUM_W = 32;

  typedef logic signed [LUT_WIDTH-1:0] lut_data_t;
  typedef logic [CHECKSUM_W-1:0] checksum_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } lut_loader_state_t;

endpackage

// File: rtl/lut_loader.sv
// Runtime writer for the activation lookup table: streams DEPTH signed entries
// into the external table RAM, checks monotonicity and accumulates a checksum.
module lut_loader
  import lstm_pkg::*;
#(
  parameter int DEPTH     = 888,
  parameter int WIDTH     = 16,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int MONOTONIC = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [WIDTH-1:0]  s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic signed [WIDTH-1:0]  wr_data,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output checksum_t                checksum
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  lut_loader_state_t        state;
  logic [ADDR_W-1:0]        idx;
  logic signed [WIDTH-1:0]  prev;
  logic                     accept;
  logic                     violation;
  checksum_t                entry_ext;

  // s_ready depends on the state register only, never on s_valid.
  assign s_ready = (state == ST_LOAD);
  assign busy    = (state == ST_LOAD);
  assign accept  = s_ready && s_valid;

  // Entry 0 has no predecessor, so it is never checked.
  assign violation = (MONOTONIC != 0) && (idx != '0) && (s_data < prev);
  assign entry_ext = {{(CHECKSUM_W-WIDTH){s_data[WIDTH-1]}}, s_data};

  // NOTE: every register below is updated with non-blocking assignments so all
  // of them see the pre-edge values of state, idx and prev in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      idx      <= '0;
      prev     <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
      checksum <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        ST_LOAD: begin
          if (accept) begin
            prev <= s_data;
            if (violation) begin
              state <= ST_ERROR;
              error <= 1'b1;
            end else begin
              wr_en    <= 1'b1;
              wr_addr  <= idx;
              wr_data  <= s_data;
              checksum <= checksum + entry_ext;
              if (idx == LAST_IDX) begin
                state <= ST_DONE;
                done  <= 1'b1;
              end else begin
                idx <= idx + 1'b1;
              end
            end
          end
        end
        default: begin
          // IDLE, DONE and ERROR all restart a fresh load on start.
          if (start) begin
            state    <= ST_LOAD;
            idx      <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
            checksum <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lut_loader.sv
// Bench for lut_loader (DEPTH=4): one checked instance per MONOTONIC setting,
// an abstract load model compared every cycle, and directed literal checks.
module tb_lut_loader;

  localparam int DEPTH  = 4;
  localparam int WIDTH  = 16;
  localparam int ADDR_W = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] start = 2'b00;
  logic signed [WIDTH-1:0] s_data = '0;
  logic s_valid = 1'b0;

  logic [1:0] s_ready, wr_en, busy, done, error;
  logic [ADDR_W-1:0] wr_addr [2];
  logic signed [WIDTH-1:0] wr_data [2];
  logic [31:0] checksum [2];

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  typedef struct { int addr; int data; } wr_t;
  wr_t wlog0[$];
  wr_t wlog1[$];
  int stim[$];

  always #5 clk = ~clk;

  lut_loader #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_W(ADDR_W), .MONOTONIC(1)) dut_mono (
    .clk(clk), .rst(rst), .start(start[0]), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready[0]), .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]),
    .busy(busy[0]), .done(done[0]), .error(error[0]), .checksum(checksum[0]));

  lut_loader #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_W(ADDR_W), .MONOTONIC(0)) dut_free (
    .clk(clk), .rst(rst), .start(start[1]), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready[1]), .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]),
    .busy(busy[1]), .done(done[1]), .error(error[1]), .checksum(checksum[1]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Abstract model: a load is "open" until DEPTH entries have been taken or a
  // decreasing entry is seen; each taken entry becomes exactly one write next cycle.
  bit          m_open [2];
  bit          m_done [2];
  bit          m_err  [2];
  int          m_cnt  [2];
  int          m_last [2];
  int unsigned m_sum  [2];
  bit          m_wen  [2];
  int          m_waddr[2];
  int          m_wdata[2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      m_wen[k] = 1'b0;
      if (rst) begin
        m_open[k] = 0; m_done[k] = 0; m_err[k] = 0; m_cnt[k] = 0;
        m_sum[k] = 0; m_waddr[k] = 0; m_wdata[k] = 0;
      end else if (!m_open[k]) begin
        if (start[k]) begin
          m_open[k] = 1; m_cnt[k] = 0; m_sum[k] = 0; m_done[k] = 0; m_err[k] = 0;
        end
      end else if (s_valid) begin
        if (k == 0 && m_cnt[k] > 0 && int'(s_data) < m_last[k]) begin
          m_open[k] = 0;
          m_err[k]  = 1;
        end else begin
          m_wen[k]   = 1;
          m_waddr[k] = m_cnt[k];
          m_wdata[k] = int'(s_data);
          m_sum[k]   = m_sum[k] + int'(s_data);
          m_cnt[k]++;
          if (m_cnt[k] == DEPTH) begin
            m_open[k] = 0;
            m_done[k] = 1;
          end
        end
        m_last[k] = int'(s_data);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("cyc%0d.wr_en", k),    32'(wr_en[k]),   32'(m_wen[k]));
        check($sformatf("cyc%0d.s_ready", k),  32'(s_ready[k]), 32'(m_open[k]));
        check($sformatf("cyc%0d.busy", k),     32'(busy[k]),    32'(m_open[k]));
        check($sformatf("cyc%0d.done", k),     32'(done[k]),    32'(m_done[k]));
        check($sformatf("cyc%0d.error", k),    32'(error[k]),   32'(m_err[k]));
        check($sformatf("cyc%0d.checksum", k), checksum[k],     m_sum[k]);
        if (m_wen[k]) begin
          check($sformatf("cyc%0d.wr_addr", k), 32'(wr_addr[k]), m_waddr[k]);
          check($sformatf("cyc%0d.wr_data", k), int'(wr_data[k]), m_wdata[k]);
        end
      end
      if (wr_en[0]) wlog0.push_back('{int'(wr_addr[0]), int'(wr_data[0])});
      if (wr_en[1]) wlog1.push_back('{int'(wr_addr[1]), int'(wr_data[1])});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int k);
    start[k] = 1'b1;
    tick();
    start[k] = 1'b0;
  endtask

  // Drives stim[]; gaps inserts an idle cycle after each entry; a start pulse to
  // instance k is overlaid on entry index mid (negative for none).
  task automatic stream(input bit gaps, input int k, input int mid);
    foreach (stim[i]) begin
      s_valid = 1'b1;
      s_data  = WIDTH'(stim[i]);
      if (i == mid) start[k] = 1'b1;
      tick();
      start[k] = 1'b0;
      if (gaps) begin
        s_valid = 1'b0;
        tick();
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic check_log(input string name, input int k, input int exp[$]);
    wr_t q[$];
    q = (k == 0) ? wlog0 : wlog1;
    check({name, ".nwrites"}, q.size(), exp.size());
    foreach (exp[i]) begin
      if (i < q.size()) begin
        check($sformatf("%s.addr%0d", name, i), q[i].addr, i);
        check($sformatf("%s.data%0d", name, i), q[i].data, exp[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    tick(); tick();
    cmp_en = 1'b1;
    rst = 1'b0;

    // Idle: s_valid pulses must not write.
    for (int i = 0; i < 5; i++) begin
      s_valid = i[0];
      s_data  = 16'sd100;
      tick();
    end
    s_valid = 1'b0;
    check("idle.nwrites", wlog0.size(), 0);
    check("idle.busy", 32'(busy[0]), 0);
    check("idle.s_ready", 32'(s_ready[0]), 0);
    check("idle.done", 32'(done[0]), 0);
    check("idle.error", 32'(error[0]), 0);
    check("idle.checksum", checksum[0], 0);
    check("idle.wr_addr", 32'(wr_addr[0]), 0);
    check("idle.wr_data", int'(wr_data[0]), 0);

    // Back-to-back full load.
    pulse_start(0);
    check("a.busy_after_start", 32'(busy[0]), 1);
    stim = '{-256, -10, 0, 256};
    stream(1'b0, 0, -1);
    check("a.done", 32'(done[0]), 1);
    check("a.busy", 32'(busy[0]), 0);
    tick(); tick();
    check_log("a", 0, '{-256, -10, 0, 256});
    check("a.checksum", checksum[0], 32'hFFFF_FFF6);
    check("a.done_held", 32'(done[0]), 1);
    wlog0.delete();

    // Same stream with s_valid gaps.
    pulse_start(0);
    check("b.done_cleared", 32'(done[0]), 0);
    stream(1'b1, 0, -1);
    tick();
    check_log("b", 0, '{-256, -10, 0, 256});
    check("b.checksum", checksum[0], 32'hFFFF_FFF6);
    check("b.done", 32'(done[0]), 1);
    wlog0.delete();

    // Monotonic violation on the third entry.
    pulse_start(0);
    stim = '{5, 7, 6};
    stream(1'b0, 0, -1);
    check("c.error", 32'(error[0]), 1);
    check("c.s_ready", 32'(s_ready[0]), 0);
    check("c.wr_en", 32'(wr_en[0]), 0);
    tick(); tick();
    check_log("c", 0, '{5, 7});
    check("c.checksum", checksum[0], 12);
    check("c.done", 32'(done[0]), 0);
    check("c.error_held", 32'(error[0]), 1);
    wlog0.delete();

    // Check disabled: the decreasing stream loads completely.
    pulse_start(1);
    stim = '{5, 7, 6, 1};
    stream(1'b0, 1, -1);
    tick();
    check_log("d", 1, '{5, 7, 6, 1});
    check("d.done", 32'(done[1]), 1);
    check("d.error", 32'(error[1]), 0);
    check("d.checksum", checksum[1], 19);
    check("d.mono_untouched", wlog0.size(), 0);

    // Reset mid-load, then a full load with a stray start in the middle.
    pulse_start(0);
    stim = '{1, 2};
    stream(1'b0, 0, -1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("e.busy_after_rst", 32'(busy[0]), 0);
    check("e.done_after_rst", 32'(done[0]), 0);
    check("e.checksum_after_rst", checksum[0], 0);
    wlog0.delete();
    pulse_start(0);
    stim = '{-3, 4, 4, 9};
    stream(1'b0, 0, 2);
    tick();
    check_log("e", 0, '{-3, 4, 4, 9});
    check("e.checksum", checksum[0], 14);
    check("e.done", 32'(done[0]), 1);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
